out_buffer: RTL and testbench

OUT_BUFFER -- requirements
Module: out_buffer

---
 rtl/out_buffer_pkg.sv | 18 +
 rtl/out_buffer_frame_counter.sv | 29 ++
 rtl/out_buffer.sv | 113 +++++++++++
 tb/tb_out_buffer.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/out_buffer_pkg.sv
// Shared definitions for the result-path controllers:
// default buffer geometry and the output FSM encoding.
package out_buffer_pkg;

    localparam int DEF_WIDTH     = 16;
    localparam int DEF_DEPTH     = 4;
    localparam int DEF_FRAME_LEN = 4;

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } out_state_t;

    function automatic int cnt_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/out_buffer_frame_counter.sv
// Modulo-FRAME_LEN pop counter; wrap flags the pop that
// completes a frame so the parent can register a pulse.
module frame_counter
    import out_buffer_pkg::*;
#(
    parameter int FRAME_LEN = DEF_FRAME_LEN
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    output logic wrap
);

    localparam int FW = cnt_bits(FRAME_LEN);
    localparam logic [FW-1:0] LAST = FW'(FRAME_LEN - 1);

    logic [FW-1:0] value;

    assign wrap = inc && (value == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            value <= '0;
        end else if (inc) begin
            value <= wrap ? '0 : value + FW'(1);
        end
    end

endmodule

// File: rtl/out_buffer.sv
// Circular result buffer between the wrapper controller and a
// consumer, with head presentation FSM and frame tracking.
module out_buffer
    import out_buffer_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int FRAME_LEN = DEF_FRAME_LEN
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_req,
    input  logic [WIDTH-1:0]         wr_data,
    output logic                     full,
    output logic                     out_valid,
    output logic [WIDTH-1:0]         out_data,
    input  logic                     out_ack,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     frame_done,
    output logic                     overflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count_next;
    logic             push;
    logic             pop;
    logic             drop;
    logic             frame_wrap;
    out_state_t       state;
    out_state_t       state_next;

    // full is the registered flag, so a pop cannot rescue a write
    assign push      = wr_req && !full;
    assign drop      = wr_req && full;
    assign pop       = out_valid && out_ack;
    assign out_valid = (state == PRESENT);
    assign out_data  = mem[rd_ptr];

    always_comb begin
        count_next = count;
        if (push && !pop) begin
            count_next = count + CW'(1);
        end else if (pop && !push) begin
            count_next = count - CW'(1);
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (count_next != '0) begin
                    state_next = PRESENT;
                end
            end
            PRESENT: begin
                if (pop && (count_next == '0)) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            full       <= 1'b0;
            overflow   <= 1'b0;
            frame_done <= 1'b0;
            state      <= IDLE;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (drop) begin
                overflow <= 1'b1;
            end
            count      <= count_next;
            full       <= (count_next == FULL_CNT);
            frame_done <= frame_wrap;
            state      <= state_next;
        end
    end

    // storage survives reset; out_data is only meaningful with out_valid
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    frame_counter #(
        .FRAME_LEN (FRAME_LEN)
    ) u_frame_counter (
        .clk  (clk),
        .rst  (rst),
        .inc  (pop),
        .wrap (frame_wrap)
    );

endmodule

// File: tb/tb_out_buffer.sv
// Scoreboard bench for out_buffer: queue-based reference model,
// directed scenarios followed by randomized traffic.
module tb_out_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_req;
    logic [15:0] wr_data;
    logic        full;
    logic        out_valid;
    logic [15:0] out_data;
    logic        out_ack;
    logic [2:0]  count;
    logic        frame_done;
    logic        overflow;

    always #5 clk = ~clk;

    out_buffer dut (
        .clk        (clk),
        .rst        (rst),
        .wr_req     (wr_req),
        .wr_data    (wr_data),
        .full       (full),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ack    (out_ack),
        .count      (count),
        .frame_done (frame_done),
        .overflow   (overflow)
    );

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [15:0] exp_q[$];
    int          mcount   = 0;
    int          mframe   = 0;
    bit          movf     = 0;
    bit          mfd      = 0;
    bit          model_ok = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // one clock: drive, check status against the model, advance model
    task automatic cycle(input bit wr, input logic [15:0] d,
                         input bit ack, input bit r);
        bit mpop;
        bit mpush;
        wr_req  = wr;
        wr_data = d;
        out_ack = ack;
        rst     = r;
        @(negedge clk);
        if (model_ok) begin
            chk("count", {29'd0, count}, mcount);
            chk("full", {31'd0, full}, {31'd0, mcount == 4});
            chk("out_valid", {31'd0, out_valid}, {31'd0, mcount > 0});
            chk("overflow", {31'd0, overflow}, {31'd0, movf});
            chk("frame_done", {31'd0, frame_done}, {31'd0, mfd});
        end
        if (r) begin
            mcount = 0;
            mframe = 0;
            movf   = 0;
            mfd    = 0;
            exp_q.delete();
            model_ok = 1;
        end else begin
            mpop  = (mcount > 0) && ack;
            mpush = wr && (mcount < 4);
            if (wr && mcount == 4) movf = 1;
            mfd = 0;
            if (mpop) begin
                mframe++;
                if (mframe == 4) begin
                    mframe = 0;
                    mfd    = 1;
                end
            end
            if (mpush) exp_q.push_back(d);
            mcount = mcount + int'(mpush) - int'(mpop);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input bit ack);
        for (int i = 0; i < n; i++) cycle(0, 16'h0, ack, 0);
    endtask

    // monitor: the presented head must match the oldest expected word
    always @(negedge clk) begin
        if (model_ok && rst === 1'b0 && out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL head: out_valid=1 data %h, expected none",
                         out_data);
            end else begin
                chk("head", {16'd0, out_data}, {16'd0, exp_q[0]});
                if (out_ack === 1'b1) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        wr_req  = 0;
        wr_data = 0;
        out_ack = 0;
        rst     = 1;
        cycle(0, 16'h0, 0, 1);
        idle(1, 0);

        // single word held without ack
        cycle(1, 16'h1234, 0, 0);
        idle(5, 0);

        // fill and overflow, then back-to-back drain
        cycle(0, 16'h0, 0, 1);
        for (int i = 1; i <= 5; i++) cycle(1, 16'(i), 0, 0);
        idle(2, 0);
        idle(4, 1);
        idle(3, 0);

        // simultaneous write and pop at count 2
        cycle(1, 16'hA001, 0, 0);
        cycle(1, 16'hA002, 0, 0);
        cycle(1, 16'hA003, 1, 0);
        idle(1, 0);
        idle(4, 1);

        // pointer wrap: 10 words with alternating ack
        cycle(0, 16'h0, 0, 1);
        for (int i = 0; i < 10; i++) begin
            cycle(1, 16'hB000 + 16'(i), i[0], 0);
            cycle(0, 16'h0, ~i[0], 0);
        end
        idle(8, 1);

        // reset mid-operation with overflow and a partial frame
        cycle(0, 16'h0, 0, 1);
        for (int i = 0; i < 5; i++) cycle(1, 16'hC000 + 16'(i), 0, 0);
        cycle(0, 16'h0, 1, 0);
        cycle(0, 16'h0, 0, 1);
        idle(1, 0);
        for (int i = 0; i < 4; i++) cycle(1, 16'hD000 + 16'(i), 0, 0);
        idle(3, 1);
        idle(3, 1);

        // randomized traffic
        for (int i = 0; i < 500; i++) begin
            cycle($urandom_range(0, 99) < 60, 16'($urandom),
                  $urandom_range(0, 99) < 55,
                  $urandom_range(0, 99) == 0);
        end
        idle(8, 1);
        chk("drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
